// File: rtl/dcache_arb_pkg.sv
// Shared types and default sizing for the DCache port arbiters.
// The typedefs match the default configuration; the arbiters rebuild them from their own parameters.
package dcache_arb_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_RD_LATENCY   = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 7;

  function automatic int unsigned ageWidth(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

  localparam int unsigned DEF_AGE_W = ageWidth(DEF_STARVE_LIMIT);

  typedef logic [DEF_NUM_REQ-1:0] ReqOneHot;
  typedef logic [DEF_AGE_W-1:0]   AgeCount;

  typedef struct packed {
    logic     valid;
    ReqOneHot id;
  } RspPipeEntry;

endpackage

// File: rtl/rr_starve_picker.sv
// Combinational winner select: a starved requester (lowest index) beats round-robin order.
// Shared with the write-port arbiter.
module rr_starve_picker #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned AgeW        = 3,
  parameter int unsigned StarveLimit = 7,
  parameter int unsigned IdxW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                   en_i,
  input  logic [NumReq-1:0]      valid_i,
  input  logic [NumReq*AgeW-1:0] age_i,
  input  logic [IdxW-1:0]        rr_ptr_i,
  output logic                   found_o,
  output logic [IdxW-1:0]        winner_o,
  output logic [NumReq-1:0]      grant_o
);

  logic            starved_found;
  logic [IdxW-1:0] starved_idx;
  logic [IdxW-1:0] rr_idx;
  int unsigned     idx;

  always_comb begin
    starved_found = 1'b0;
    starved_idx   = '0;
    rr_idx        = '0;
    idx           = 0;
    // Descending scans: the last hit wins, i.e. lowest index / nearest to rr_ptr.
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (valid_i[i] && (age_i[i*AgeW +: AgeW] == AgeW'(StarveLimit))) begin
        starved_found = 1'b1;
        starved_idx   = IdxW'(i);
      end
    end
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = 32'(rr_ptr_i) + 32'(k);
      if (idx >= NumReq) idx = idx - NumReq;
      if (valid_i[IdxW'(idx)]) rr_idx = IdxW'(idx);
    end
    found_o  = en_i & (|valid_i);
    winner_o = starved_found ? starved_idx : rr_idx;
    grant_o  = '0;
    if (found_o) grant_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/dcache_read_port_arbiter.sv
// Shares the DCache LSU read port between load-side requesters and routes each
// hit/data response back to the requester that issued it.
module dcache_read_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned RD_LATENCY   = DEF_RD_LATENCY,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned AL_W         = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_uncachable,
  input  logic [NUM_REQ*AL_W-1:0]   req_al_ptr,
  input  logic [NUM_REQ-1:0]        req_flush,
  output logic [NUM_REQ-1:0]        req_grant,
  input  logic                      dc_read_busy,
  output logic                      dc_read_req,
  output logic [ADDR_W-1:0]         dc_read_addr,
  output logic                      dc_read_uncachable,
  output logic [AL_W-1:0]           dc_read_al_ptr,
  input  logic                      dc_read_hit,
  input  logic [LINE_W-1:0]         dc_read_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_hit,
  output logic [LINE_W-1:0]         rsp_data
);

  localparam int unsigned AgeW = ageWidth(STARVE_LIMIT);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic               valid;
    logic [NUM_REQ-1:0] id;
  } PipeEntry;

  logic                    found;
  logic [IdxW-1:0]         winner;
  logic [IdxW-1:0]         rr_ptr_q;
  logic [NUM_REQ*AgeW-1:0] age_q, age_d;
  logic [NUM_REQ-1:0]      port_id_q;
  PipeEntry [RD_LATENCY-1:0] pipe_q, pipe_d;
  PipeEntry                last_stage;
  logic [ADDR_W-1:0]       sel_addr;
  logic                    sel_unc;
  logic [AL_W-1:0]         sel_al;

  rr_starve_picker #(
    .NumReq      (NUM_REQ),
    .AgeW        (AgeW),
    .StarveLimit (STARVE_LIMIT),
    .IdxW        (IdxW)
  ) u_picker (
    .en_i     (rst & ~dc_read_busy),
    .valid_i  (req_valid),
    .age_i    (age_q),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (found),
    .winner_o (winner),
    .grant_o  (req_grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_unc  = 1'b0;
    sel_al   = '0;
    age_d    = age_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_unc  = req_uncachable[i];
        sel_al   = req_al_ptr[i*AL_W +: AL_W];
      end
      if (!dc_read_busy) begin
        if (!req_valid[i] || req_grant[i]) begin
          age_d[i*AgeW +: AgeW] = '0;
        end else if (found && (age_q[i*AgeW +: AgeW] != AgeW'(STARVE_LIMIT))) begin
          age_d[i*AgeW +: AgeW] = age_q[i*AgeW +: AgeW] + 1'b1;
        end
      end
    end
  end

  // Flush kills matching ids everywhere, including the request sitting on the port now;
  // a grant made in the flush cycle is still in the picker and survives.
  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = dc_read_req;
    pipe_d[0].id    = port_id_q & ~req_flush;
    for (int s = 1; s < RD_LATENCY; s++) begin
      pipe_d[s].valid = pipe_q[s-1].valid;
      pipe_d[s].id    = pipe_q[s-1].id & ~req_flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q           <= '0;
      age_q              <= '0;
      port_id_q          <= '0;
      pipe_q             <= '0;
      dc_read_req        <= 1'b0;
      dc_read_addr       <= '0;
      dc_read_uncachable <= 1'b0;
      dc_read_al_ptr     <= '0;
    end else begin
      age_q       <= age_d;
      pipe_q      <= pipe_d;
      port_id_q   <= req_grant;
      dc_read_req <= found;
      if (found) begin
        rr_ptr_q           <= (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        dc_read_addr       <= sel_addr;
        dc_read_uncachable <= sel_unc;
        dc_read_al_ptr     <= sel_al;
      end
    end
  end

  assign last_stage = pipe_q[RD_LATENCY-1];
  assign rsp_valid  = last_stage.valid ? (last_stage.id & ~req_flush) : '0;
  assign rsp_hit    = dc_read_hit & (|rsp_valid);
  assign rsp_data   = dc_read_data;

endmodule

// File: tb/tb_dcache_read_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected port requests and responses, monitors pop and compare.
// A second instance with a starvation limit of 1 exercises the starvation override.
module tb_dcache_read_port_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int ALW = 6;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_uncachable, req_flush, req_grant, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*ALW-1:0] req_al_ptr;
  logic            dc_read_busy, dc_read_req, dc_read_uncachable, dc_read_hit, rsp_hit;
  logic [AW-1:0]   dc_read_addr;
  logic [ALW-1:0]  dc_read_al_ptr;
  logic [LW-1:0]   dc_read_data, rsp_data;

  logic [NR-1:0]   s_valid, s_grant, s_rsp_valid;
  logic            s_req, s_unc, s_rsp_hit;
  logic [AW-1:0]   s_addr;
  logic [ALW-1:0]  s_al;
  logic [LW-1:0]   s_rsp_data;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { int cyc; logic [AW-1:0] addr; logic unc; logic [ALW-1:0] al; } PortExp;
  typedef struct { int cyc; logic [NR-1:0] id; logic [AW-1:0] addr; } RspExp;
  typedef struct { int cyc; logic [AW-1:0] addr; } CacheEnt;
  PortExp  port_q[$];
  RspExp   rsp_q[$];
  CacheEnt cache_q[$];

  dcache_read_port_arbiter #(
    .NUM_REQ(NR), .RD_LATENCY(LAT), .STARVE_LIMIT(7), .ADDR_W(AW), .LINE_W(LW), .AL_W(ALW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_uncachable(req_uncachable), .req_al_ptr(req_al_ptr), .req_flush(req_flush),
    .req_grant(req_grant), .dc_read_busy(dc_read_busy), .dc_read_req(dc_read_req),
    .dc_read_addr(dc_read_addr), .dc_read_uncachable(dc_read_uncachable),
    .dc_read_al_ptr(dc_read_al_ptr), .dc_read_hit(dc_read_hit), .dc_read_data(dc_read_data),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data)
  );

  dcache_read_port_arbiter #(
    .NUM_REQ(NR), .RD_LATENCY(LAT), .STARVE_LIMIT(1), .ADDR_W(AW), .LINE_W(LW), .AL_W(ALW)
  ) dut_starve (
    .clk(clk), .rst(rst), .req_valid(s_valid), .req_addr(req_addr),
    .req_uncachable(req_uncachable), .req_al_ptr(req_al_ptr), .req_flush(4'b0),
    .req_grant(s_grant), .dc_read_busy(1'b0), .dc_read_req(s_req),
    .dc_read_addr(s_addr), .dc_read_uncachable(s_unc),
    .dc_read_al_ptr(s_al), .dc_read_hit(1'b0), .dc_read_data(128'b0),
    .rsp_valid(s_rsp_valid), .rsp_hit(s_rsp_hit), .rsp_data(s_rsp_data)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [AW-1:0] addrOf(input int c, input int i);
    return {8'hA0, 16'(c), 8'(i)};
  endfunction
  function automatic logic [LW-1:0] lineOf(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'd1};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, want nothing (cycle %0d)", name, act, cyc);
  endtask

  // Called at posedge+1; drives one cycle of main-DUT stimulus and checks its grant.
  task automatic step(input logic [NR-1:0] v, input logic b, input logic [NR-1:0] fl,
                      input logic [NR-1:0] eg, input bit keep);
    req_valid    = v;
    dc_read_busy = b;
    req_flush    = fl;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]     = addrOf(cyc, i);
      req_uncachable[i]        = cyc[0] ^ i[1];
      req_al_ptr[i*ALW +: ALW] = 6'(cyc * 4 + i);
    end
    @(negedge clk);
    check("grant", 128'(req_grant), 128'(eg));
    for (int i = 0; i < NR; i++) begin
      if (eg[i]) begin
        port_q.push_back('{cyc + 1, addrOf(cyc, i), cyc[0] ^ i[1], 6'(cyc * 4 + i)});
        if (keep) rsp_q.push_back('{cyc + 1 + LAT, eg, addrOf(cyc, i)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic [NR-1:0] v, input logic [NR-1:0] eg);
    s_valid = v;
    @(negedge clk);
    check("starve_grant", 128'(s_grant), 128'(eg));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic checkResetOutputs();
    check("rst_grant", 128'(req_grant), 128'd0);
    check("rst_s_grant", 128'(s_grant), 128'd0);
    check("rst_req", 128'(dc_read_req), 128'd0);
    check("rst_port", 128'({dc_read_addr, dc_read_uncachable, dc_read_al_ptr}), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
  endtask

  // DCache model: answers each port request LAT cycles later.
  initial begin
    CacheEnt ce;
    dc_read_hit  = 1'b0;
    dc_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      while (cache_q.size() > 0 && cache_q[0].cyc + LAT < cyc) cache_q.delete(0);
      if (cache_q.size() > 0 && cache_q[0].cyc + LAT == cyc) begin
        ce = cache_q.pop_front();
        dc_read_hit  = ce.addr[8];
        dc_read_data = lineOf(ce.addr);
      end else begin
        dc_read_hit  = 1'b0;
        dc_read_data = '0;
      end
      @(negedge clk);
      if (dc_read_req) cache_q.push_back('{cyc, dc_read_addr});
    end
  end

  // Port and response monitors.
  initial begin
    PortExp pe;
    RspExp  re;
    forever begin
      @(negedge clk);
      if (dc_read_req) begin
        if (port_q.size() == 0) begin
          unexpected("port_req", 128'(dc_read_addr));
        end else begin
          pe = port_q.pop_front();
          check("port_cycle", 128'(cyc), 128'(pe.cyc));
          check("port_fields", 128'({dc_read_addr, dc_read_uncachable, dc_read_al_ptr}),
                128'({pe.addr, pe.unc, pe.al}));
        end
      end
      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          unexpected("rsp_valid", 128'(rsp_valid));
        end else begin
          re = rsp_q.pop_front();
          check("rsp_cycle", 128'(cyc), 128'(re.cyc));
          check("rsp_id", 128'(rsp_valid), 128'(re.id));
          check("rsp_hit", 128'(rsp_hit), 128'(re.addr[8]));
          check("rsp_data", rsp_data, lineOf(re.addr));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    req_valid = '0; req_uncachable = '0; req_flush = '0; req_addr = '0; req_al_ptr = '0;
    dc_read_busy = 1'b0; s_valid = '0;
    #2;
    req_valid = 4'hF;
    s_valid = 4'hF;
    #10;
    checkResetOutputs();
    req_valid = '0;
    s_valid = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Starvation override with limit 1: grants 1,2,1(not 3),3,0,3(not 2).
    sstep(4'b0010, 4'b0010);
    sstep(4'b0110, 4'b0100);
    sstep(4'b1010, 4'b0010);
    sstep(4'b1000, 4'b1000);
    sstep(4'b1001, 4'b0001);
    sstep(4'b1100, 4'b1000);
    s_valid = '0;

    // Round robin, all valid.
    for (int k = 0; k < 8; k++) step(4'hF, 1'b0, 4'h0, 4'(1 << (k % 4)), 1'b1);

    // Wrap-around: move rr_ptr to 3, then 3 -> 0 -> 1.
    step(4'b0100, 1'b0, 4'h0, 4'b0100, 1'b1);
    step(4'b1001, 1'b0, 4'h0, 4'b1000, 1'b1);
    step(4'b1001, 1'b0, 4'h0, 4'b0001, 1'b1);
    step(4'b1001, 1'b0, 4'h0, 4'b1000, 1'b1);

    // Busy: in-flight responses still complete, no grant until busy drops.
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b1, 4'h0, 4'h0, 1'b0);
    step(4'b0010, 1'b0, 4'h0, 4'b0010, 1'b1);

    // Flush of an older entry alongside a new grant to the same requester.
    step(4'b0100, 1'b0, 4'h0, 4'b0100, 1'b0);
    step(4'b0000, 1'b0, 4'h0, 4'h0, 1'b0);
    step(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1);
    idle(3);

    // Flush while the entry is in the last stage kills rsp_valid combinationally.
    step(4'b0010, 1'b0, 4'h0, 4'b0010, 1'b0);
    idle(2);
    step(4'b0000, 1'b0, 4'b0010, 4'h0, 1'b0);
    idle(1);

    // Back-to-back grants to a lone requester.
    for (int k = 0; k < 3; k++) step(4'b1000, 1'b0, 4'h0, 4'b1000, 1'b1);
    idle(LAT + 2);

    // Reset mid-flight: drop everything in flight.
    step(4'b0001, 1'b0, 4'h0, 4'b0001, 1'b1);
    rst = 1'b0;
    port_q.delete();
    rsp_q.delete();
    #2;
    checkResetOutputs();
    @(posedge clk);
    #2 rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    idle(LAT + 3);

    // Post-reset arbitration restarts from requester 0.
    step(4'b0110, 1'b0, 4'h0, 4'b0010, 1'b1);
    idle(LAT + 2);

    check("port_queue_drained", 128'(port_q.size()), 128'd0);
    check("rsp_queue_drained", 128'(rsp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_read_port_arbiter.md
Name: dcache_read_port_arbiter

Overview:
- Shares one DCache LSU read port between NUM_REQ load-side requesters, e.g. load pipes, the replay queue and a prefetcher.
- Round-robin arbitration with a starvation override; each request is registered onto the port one cycle after grant.
- Tracks the winner through the fixed DCache read latency and routes hit/data back to it.
- Sits between the memory execution stages and the DCache read port inputs (dcReadReq/dcReadAddr/dcReadUncachable/dcReadActiveListPtr).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RD_LATENCY, 2, cycles from port request to dcReadHit/dcReadData valid (1..4).
- STARVE_LIMIT, 7, lost arbitration rounds before forced priority.
- ADDR_W, 32, physical address width (PhyAddrPath).
- LINE_W, 128, DCache line width (DCacheLinePath).
- AL_W, 6, active-list pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  request held by requester until granted.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address.
- req_uncachable  in  NUM_REQ  per-requester uncachable flag.
- req_al_ptr  in  NUM_REQ*AL_W  per-requester active-list pointer.
- req_flush  in  NUM_REQ  drop the in-flight response for that requester (recovery).
- req_grant  out  NUM_REQ  one-hot grant, combinational, same cycle as winning req_valid.
- dc_read_busy  in  1  port cannot accept a request this cycle.
- dc_read_req  out  1  registered port request.
- dc_read_addr  out  ADDR_W  registered port address.
- dc_read_uncachable  out  1  registered uncachable flag.
- dc_read_al_ptr  out  AL_W  registered active-list pointer.
- dc_read_hit  in  1  hit, valid RD_LATENCY cycles after dc_read_req.
- dc_read_data  in  LINE_W  line data, same timing as hit.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_hit  out  1  hit for the responding requester.
- rsp_data  out  LINE_W  line data, passed through combinationally.

Behaviour:
- Reset:
  - rr_ptr=0, all age counters=0, response pipeline cleared.
  - dc_read_req=0, addr/uncachable/al_ptr=0, rsp_valid=0.
  - req_grant=0 while rst asserted.
- Grant (comb):
  - If dc_read_busy=1: no grant.
  - Otherwise the winner is the lowest-index requester whose age == STARVE_LIMIT.
  - If none is starved: the first valid requester at or after rr_ptr, searching cyclically with wrap at NUM_REQ-1 -> 0.
  - At most one grant per cycle.
- Port register:
  - On a grant, the next cycle has dc_read_req=1 carrying the winner's addr/uncachable/al_ptr.
  - On no grant, dc_read_req=0 and the data fields hold their previous values.
- rr_ptr: on a grant, next value = winner+1 mod NUM_REQ; unchanged otherwise.
- Age:
  - Per requester, a saturating 3-bit counter (width clog2(STARVE_LIMIT+1)).
  - +1 when req_valid=1 and another requester is granted.
  - Cleared when granted or when req_valid=0.
  - Unchanged in busy cycles.
- Response tracking:
  - Shift pipeline of RD_LATENCY stages holding {valid, one-hot id}.
  - Stage 0 is loaded with the cycle dc_read_req is issued.
  - rsp_valid = last-stage valid ? id : 0, ANDed with ~flush_mask.
  - req_flush clears the matching id bits in every stage in the same cycle (combinational kill of rsp_valid) and on the next edge.
- Simultaneous events: grant and flush to the same requester in one cycle -> the new grant is kept and the flush affects only older in-flight entries.
- Busy rising mid-stream: already-issued requests still complete; the arbiter simply stops granting.
- Back-to-back grants to one requester are allowed if it is the only one valid.
- Reset mid-operation discards all in-flight responses; no rsp_valid after reset is released.

Decomposition:
- Package dcache_arb_pkg holds:
  - ReqOneHot typedef (logic [NUM_REQ-1:0]).
  - AgeCount typedef.
  - RspPipeEntry struct {valid, id}.
  - Constants STARVE_LIMIT and RD_LATENCY defaults.
- One natural sub-module: rr_starve_picker. Combinational winner selection from req_valid, ages and rr_ptr; reused for the write-port arbiter.

Test Plan:
- Round-robin: all 4 requesters valid for 8 cycles, busy=0 -> grants 0,1,2,3,0,1,2,3; dc_read_req cycles 1..8; rsp_valid id order identical at cycles 3..10 (RD_LATENCY=2).
- Wrap-around: req 3 and req 0 valid, rr_ptr=3 -> grant 3, then 0; rr_ptr goes 3->0->1.
- Starvation: force rr so req 2 loses 7 consecutive rounds (req 2 masked by rr position via toggling others) -> 8th cycle grant=req 2 even though rr_ptr points to 0; age[2] resets to 0.
- Busy: busy=1 for 3 cycles with req 1 valid -> req_grant=0, dc_read_req=0, age unchanged; busy=0 -> grant 1 immediately, request on the next cycle.
- Flush: grant req 2 at t, assert req_flush[2] at t+2 -> rsp_valid[2] stays 0 at t+3; a simultaneous new grant to 2 at t+2 responds at t+5.
- Reset mid-flight: grant at t, rst low at t+1 -> all outputs 0; after release no stale rsp_valid.
